// File: rtl/bridge_info_regs_pkg.sv
// Shared definitions for the bridge information register block.
//   word_t          : one 32-bit bridge register word
//   MAX_RD_LATENCY  : deepest read pipeline the block supports
//   *_idx/ctrl_base : word-index layout of the register regions, derived from
//                     the number of ID words and control registers
package bridge_info_regs_pkg;

  typedef logic [31:0] word_t;

  localparam int MAX_RD_LATENCY = 3;

  // First control register follows the ID words.
  function automatic int ctrl_base(input int num_id);
    return num_id;
  endfunction

  // The sticky status word follows the control registers.
  function automatic int status_idx(input int num_id, input int num_ctrl);
    return num_id + num_ctrl;
  endfunction

  // Low half of the cycle counter.
  function automatic int cnt_lo_idx(input int num_id, input int num_ctrl);
    return num_id + num_ctrl + 1;
  endfunction

  // High half of the cycle counter, served from the snapshot.
  function automatic int cnt_hi_idx(input int num_id, input int num_ctrl);
    return num_id + num_ctrl + 2;
  endfunction

endpackage

// File: rtl/bridge_read_pipe.sv
// Read-response delay line.
// Carries {valid, data} through DEPTH register stages. Data only advances
// alongside a valid beat, so the last stage keeps the previous read data
// while no response is being delivered.
//   clk, reset_n        : clock, asynchronous active-low clear
//   in_valid, in_data   : read request qualifier and decoded read word
//   out_valid, out_data : registered response, DEPTH cycles after input
module bridge_read_pipe
  import bridge_info_regs_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  in_valid,
  input  word_t in_data,
  output logic  out_valid,
  output word_t out_data
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("bridge_read_pipe: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] valid_r;
  word_t            data_r [DEPTH];

  // Shift valid every cycle; move data only with a valid beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= 32'h0000_0000;
      end
    end else begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        data_r[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        if (valid_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_data  = data_r[DEPTH-1];

endmodule

// File: rtl/bridge_info_regs.sv
// Bridge information register block.
// Serves, by word index addr[ADDR_BITS+1:2]:
//   [0, NUM_ID)                 read-only ID words
//   [NUM_ID, NUM_ID+NUM_CTRL)   read/write control registers
//   NUM_ID+NUM_CTRL             sticky write-1-to-clear status
//   +1 / +2                     cycle counter low half / high snapshot
//   anything else               UNMAPPED_VALUE
// ID_WORDS lists word 0 leftmost in its concatenation. CTRL_RESET uses the
// same layout as the ctrl port (control register 0 in bits [31:0]).
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   addr, rd, wr, wr_data    : bridge access (one-cycle strobes)
//   rd_data, rd_data_valid   : read response, RD_LATENCY cycles after rd
//   ctrl, ctrl_wr_pulse      : control register values and write pulses
//   status_set, status       : sticky status set pulses and current bits
module bridge_info_regs
  import bridge_info_regs_pkg::*;
#(
  parameter int                     ADDR_BITS      = 4,
  parameter int                     NUM_ID         = 3,
  parameter logic [NUM_ID*32-1:0]   ID_WORDS       = {NUM_ID{32'h0}},
  parameter int                     NUM_CTRL       = 2,
  parameter logic [NUM_CTRL*32-1:0] CTRL_RESET     = {NUM_CTRL{32'h0}},
  parameter int                     STATUS_W       = 8,
  parameter int                     RD_LATENCY     = 1,
  parameter logic [31:0]            UNMAPPED_VALUE = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              addr,
  input  logic                     rd,
  input  logic                     wr,
  input  logic [31:0]              wr_data,
  output logic [31:0]              rd_data,
  output logic                     rd_data_valid,
  output logic [NUM_CTRL*32-1:0]   ctrl,
  output logic [NUM_CTRL-1:0]      ctrl_wr_pulse,
  input  logic [STATUS_W-1:0]      status_set,
  output logic [STATUS_W-1:0]      status
);

  localparam int CTRL_BASE  = ctrl_base(NUM_ID);
  localparam int STATUS_IDX = status_idx(NUM_ID, NUM_CTRL);
  localparam int CNT_LO_IDX = cnt_lo_idx(NUM_ID, NUM_CTRL);
  localparam int CNT_HI_IDX = cnt_hi_idx(NUM_ID, NUM_CTRL);

  if (NUM_ID < 1 || NUM_CTRL < 1) begin : g_bad_counts
    $error("bridge_info_regs: NUM_ID and NUM_CTRL must be at least 1");
  end
  if (NUM_ID + NUM_CTRL + 3 > 2**ADDR_BITS) begin : g_bad_map
    $error("bridge_info_regs: register map does not fit in 2**ADDR_BITS words");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
    $error("bridge_info_regs: RD_LATENCY must be 1..3");
  end
  if (STATUS_W < 1 || STATUS_W > 32) begin : g_bad_status_w
    $error("bridge_info_regs: STATUS_W must be 1..32");
  end

  int                     idx_s;
  logic                   unused_addr_s;
  logic                   is_id_s;
  logic                   is_ctrl_s;
  logic [NUM_CTRL-1:0]    ctrl_wr_s;
  logic [STATUS_W-1:0]    status_clr_s;
  word_t                  id_word_s;
  word_t                  ctrl_word_s;
  word_t                  status_word_s;
  word_t                  rd_word_s;

  logic [NUM_CTRL*32-1:0] ctrl_r;
  logic [NUM_CTRL-1:0]    ctrl_wr_pulse_r;
  logic [STATUS_W-1:0]    status_r;
  logic [63:0]            cnt_r;
  word_t                  cnt_hi_snap_r;

  // The window is already selected upstream; only the word index matters.
  assign idx_s         = int'(addr[ADDR_BITS+1:2]);
  assign unused_addr_s = ^{addr[31:ADDR_BITS+2], addr[1:0]};

  // Region and write-target decode of the current access.
  always_comb begin
    is_id_s   = (idx_s < NUM_ID);
    is_ctrl_s = (idx_s >= CTRL_BASE) && (idx_s < STATUS_IDX);
    ctrl_wr_s = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      ctrl_wr_s[i] = wr && (idx_s == CTRL_BASE + i);
    end
    if (wr && (idx_s == STATUS_IDX)) begin
      status_clr_s = wr_data[STATUS_W-1:0];
    end else begin
      status_clr_s = '0;
    end
  end

  // Stage-0 read word: values as they stand in the rd cycle (pre-write).
  always_comb begin
    id_word_s = UNMAPPED_VALUE;
    for (int i = 0; i < NUM_ID; i++) begin
      id_word_s = (idx_s == i) ? ID_WORDS[(NUM_ID-1-i)*32 +: 32] : id_word_s;
    end
    ctrl_word_s = 32'h0000_0000;
    for (int i = 0; i < NUM_CTRL; i++) begin
      ctrl_word_s = (idx_s == CTRL_BASE + i) ? ctrl_r[i*32 +: 32] : ctrl_word_s;
    end
    status_word_s                 = 32'h0000_0000;
    status_word_s[STATUS_W-1:0]   = status_r;
    if (is_id_s) begin
      rd_word_s = id_word_s;
    end else if (is_ctrl_s) begin
      rd_word_s = ctrl_word_s;
    end else if (idx_s == STATUS_IDX) begin
      rd_word_s = status_word_s;
    end else if (idx_s == CNT_LO_IDX) begin
      rd_word_s = cnt_r[31:0];
    end else if (idx_s == CNT_HI_IDX) begin
      rd_word_s = cnt_hi_snap_r;
    end else begin
      rd_word_s = UNMAPPED_VALUE;
    end
  end

  // Control registers; the pulse is high while the new value is first visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r          <= CTRL_RESET;
      ctrl_wr_pulse_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (ctrl_wr_s[i]) begin
          ctrl_r[i*32 +: 32] <= wr_data;
        end
      end
      ctrl_wr_pulse_r <= ctrl_wr_s;
    end
  end

  // Sticky status: a set pulse overrides a same-cycle clear of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_r <= '0;
    end else begin
      status_r <= (status_r & ~status_clr_s) | status_set;
    end
  end

  // Free-running counter; a CNT_LO read freezes the matching high half.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r         <= 64'h0;
      cnt_hi_snap_r <= 32'h0000_0000;
    end else begin
      cnt_r <= cnt_r + 64'd1;
      if (rd && (idx_s == CNT_LO_IDX)) begin
        cnt_hi_snap_r <= cnt_r[63:32];
      end
    end
  end

  bridge_read_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_read_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rd),
    .in_data   (rd_word_s),
    .out_valid (rd_data_valid),
    .out_data  (rd_data)
  );

  assign ctrl          = ctrl_r;
  assign ctrl_wr_pulse = ctrl_wr_pulse_r;
  assign status        = status_r;

endmodule

// File: tb/tb_bridge_info_regs.sv
// Bench for bridge_info_regs: three instances (read latency 1, 2, 3) share
// one stimulus stream; a word-level reference model predicts responses.
module tb_bridge_info_regs;

  localparam logic [95:0] IDW = {32'h2024_0101, 32'h0012_3456, 32'hCAFE_F00D};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [31:0] wr_data;
  logic [7:0]  status_set;

  logic [31:0] rdd    [3];
  logic        rdv    [3];
  logic [63:0] ctrl_o [3];
  logic [1:0]  pls    [3];
  logic [7:0]  sts    [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bridge_info_regs #(.ID_WORDS(IDW), .RD_LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .rd(rd), .wr(wr), .wr_data(wr_data),
    .rd_data(rdd[0]), .rd_data_valid(rdv[0]), .ctrl(ctrl_o[0]), .ctrl_wr_pulse(pls[0]),
    .status_set(status_set), .status(sts[0]));
  bridge_info_regs #(.ID_WORDS(IDW), .RD_LATENCY(2)) dut_l2 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .rd(rd), .wr(wr), .wr_data(wr_data),
    .rd_data(rdd[1]), .rd_data_valid(rdv[1]), .ctrl(ctrl_o[1]), .ctrl_wr_pulse(pls[1]),
    .status_set(status_set), .status(sts[1]));
  bridge_info_regs #(.ID_WORDS(IDW), .RD_LATENCY(3)) dut_l3 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .rd(rd), .wr(wr), .wr_data(wr_data),
    .rd_data(rdd[2]), .rd_data_valid(rdv[2]), .ctrl(ctrl_o[2]), .ctrl_wr_pulse(pls[2]),
    .status_set(status_set), .status(sts[2]));

  // ---------------- reference model (word-level register map) ----------------
  logic [31:0] id_tab [3] = '{32'h2024_0101, 32'h0012_3456, 32'hCAFE_F00D};
  logic [31:0] m_ctrl [2];
  logic [7:0]  m_status;
  logic [63:0] m_cnt;
  logic [31:0] m_snap;
  int          k = 0;              // number of rising edges seen by tick()
  logic [31:0] exp_d [int];        // read sampled at edge k -> expected word

  function automatic logic [31:0] model_read(input int idx);
    if (idx < 3)       return id_tab[idx];
    else if (idx < 5)  return m_ctrl[idx-3];
    else if (idx == 5) return {24'h0, m_status};
    else if (idx == 6) return m_cnt[31:0];
    else if (idx == 7) return m_snap;
    else               return 32'h0;
  endfunction

  task automatic model_reset();
    m_ctrl[0] = 32'h0; m_ctrl[1] = 32'h0;
    m_status = 8'h0; m_cnt = 64'h0; m_snap = 32'h0;
  endtask

  // Advance one clock; the model applies the access that was driven.
  task automatic tick();
    int idx;
    @(posedge clk);
    k++;
    idx = int'(addr[5:2]);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (rd) begin
        exp_d[k] = model_read(idx);
        if (idx == 6) m_snap = m_cnt[63:32];
      end
      if (wr && idx == 3) m_ctrl[0] = wr_data;
      if (wr && idx == 4) m_ctrl[1] = wr_data;
      if (wr && idx == 5) m_status = m_status & ~wr_data[7:0];
      m_status = m_status | status_set;
      m_cnt = m_cnt + 64'd1;
    end
    @(negedge clk);
  endtask

  task automatic drive(input int idx, input bit r, input bit w,
                       input logic [31:0] d, input logic [7:0] s);
    addr = {26'h0, 4'(idx), 2'b00};
    rd = r; wr = w; wr_data = d; status_set = s;
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 32'h0, 8'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdv[i] !== 1'b0 || rdd[i] !== 32'h0 || ctrl_o[i] !== 64'h0 ||
          pls[i] !== 2'b00 || sts[i] !== 8'h0) begin
        failures++;
        $display("FAIL reset_state inst%0d: got v=%b d=%h ctrl=%h pulse=%b st=%h want all zero",
                 i, rdv[i], rdd[i], ctrl_o[i], pls[i], sts[i]);
      end
    end
  endtask

  task automatic test_id_back_to_back();
    int t0 = k + 1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(c, 1'b1, 1'b0, 32'h0, 8'h0); else idle();
      tick();
      for (int i = 0; i < 3; i++) begin
        int j;
        bit ev;
        j = (k - t0) - i;
        ev = (j >= 0 && j < 3);
        checks++;
        if (rdv[i] !== ev) begin
          failures++;
          $display("FAIL id_b2b_valid L%0d c%0d: got %b want %b", i+1, c, rdv[i], ev);
        end
        if (ev) begin
          checks++;
          if (rdd[i] !== id_tab[j]) begin
            failures++;
            $display("FAIL id_b2b_data L%0d word%0d: got %h want %h", i+1, j, rdd[i], id_tab[j]);
          end
        end
      end
    end
  endtask

  task automatic test_latency3_single();
    for (int c = 0; c < 6; c++) begin
      logic [31:0] want_d;
      if (c == 0) drive(0, 1'b1, 1'b0, 32'h0, 8'h0); else idle();
      tick();
      want_d = (c >= 2) ? 32'h2024_0101 : 32'hCAFE_F00D;   // holds last data when idle
      checks++;
      if (rdv[2] !== (c == 2) || rdd[2] !== want_d) begin
        failures++;
        $display("FAIL lat3_single c%0d: got v=%b d=%h want v=%b d=%h",
                 c, rdv[2], rdd[2], (c == 2), want_d);
      end
    end
  endtask

  task automatic test_unmapped_and_ignored_write();
    drive(15, 1'b1, 1'b0, 32'h0, 8'h0);
    drive(15, 1'b1, 1'b0, 32'h0, 8'h0);
    addr = {26'h0, 4'd15, 2'b00};
    tick();
    checks++;
    if (rdv[0] !== 1'b1 || rdd[0] !== 32'h0) begin
      failures++;
      $display("FAIL unmapped_read: got v=%b d=%h want v=1 d=00000000", rdv[0], rdd[0]);
    end
    drive(0, 1'b0, 1'b1, 32'hDEAD_BEEF, 8'h0);   // write to ID must be dropped
    tick();
    drive(0, 1'b1, 1'b0, 32'h0, 8'h0);
    tick();
    idle();
    checks++;
    if (rdv[0] !== 1'b1 || rdd[0] !== 32'h2024_0101) begin
      failures++;
      $display("FAIL id_write_ignored: got v=%b d=%h want v=1 d=20240101", rdv[0], rdd[0]);
    end
  endtask

  task automatic test_ctrl_write();
    drive(3, 1'b0, 1'b1, 32'h0000_00A5, 8'h0);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctrl_o[i][31:0] !== 32'hA5 || pls[i] !== 2'b01) begin
        failures++;
        $display("FAIL ctrl0_write inst%0d: got ctrl0=%h pulse=%b want 000000a5/01",
                 i, ctrl_o[i][31:0], pls[i]);
      end
    end
    tick();
    checks++;
    if (pls[0] !== 2'b00 || ctrl_o[0][31:0] !== 32'hA5) begin
      failures++;
      $display("FAIL ctrl0_pulse_width: got pulse=%b ctrl0=%h want 00/000000a5", pls[0], ctrl_o[0][31:0]);
    end
  endtask

  task automatic test_rd_wr_same_index();
    drive(4, 1'b1, 1'b1, 32'h0000_0001, 8'h0);
    tick();
    idle();
    checks++;
    if (rdv[0] !== 1'b1 || rdd[0] !== 32'h0) begin
      failures++;
      $display("FAIL rdwr_pre_value: got v=%b d=%h want v=1 d=00000000", rdv[0], rdd[0]);
    end
    checks++;
    if (ctrl_o[0][63:32] !== 32'h1 || pls[0] !== 2'b10) begin
      failures++;
      $display("FAIL rdwr_ctrl1: got ctrl1=%h pulse=%b want 00000001/10", ctrl_o[0][63:32], pls[0]);
    end
  endtask

  task automatic test_status();
    drive(0, 1'b0, 1'b0, 32'h0, 8'h81);
    tick();
    drive(5, 1'b0, 1'b1, 32'h0000_0001, 8'h01);
    tick();
    checks++;
    if (sts[0] !== 8'h81) begin
      failures++;
      $display("FAIL status_set_wins: got %h want 81", sts[0]);
    end
    drive(5, 1'b0, 1'b1, 32'h0000_0080, 8'h00);
    tick();
    drive(5, 1'b1, 1'b0, 32'h0, 8'h00);
    tick();
    idle();
    checks++;
    if (sts[0] !== 8'h01 || rdd[0] !== 32'h0000_0001) begin
      failures++;
      $display("FAIL status_w1c: got status=%h read=%h want 01/00000001", sts[0], rdd[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = $urandom;
      addr = {a[31:6], 4'($urandom_range(15, 0)), a[1:0]};
      rd = ($urandom_range(99, 0) < 60);
      wr = ($urandom_range(99, 0) < 30);
      wr_data = $urandom;
      status_set = 8'($urandom & $urandom & $urandom);
      tick();
      for (int i = 0; i < 3; i++) begin
        int t;
        bit ev;
        t = k - i;
        ev = exp_d.exists(t);
        checks++;
        if (rdv[i] !== ev) begin
          failures++;
          $display("FAIL rand_valid L%0d edge%0d: got %b want %b", i+1, k, rdv[i], ev);
        end
        if (ev) begin
          checks++;
          if (rdd[i] !== exp_d[t]) begin
            failures++;
            $display("FAIL rand_data L%0d edge%0d: got %h want %h", i+1, k, rdd[i], exp_d[t]);
          end
        end
      end
      checks++;
      if (sts[0] !== m_status || ctrl_o[0] !== {m_ctrl[1], m_ctrl[0]}) begin
        failures++;
        $display("FAIL rand_regs edge%0d: got st=%h ctrl=%h want st=%h ctrl=%h",
                 k, sts[0], ctrl_o[0], m_status, {m_ctrl[1], m_ctrl[0]});
      end
    end
    idle();
  endtask

  task automatic test_counter_snapshot();
    force dut_l1.cnt_r = 64'h0000_0001_FFFF_FFFE;
    force dut_l2.cnt_r = 64'h0000_0001_FFFF_FFFE;
    force dut_l3.cnt_r = 64'h0000_0001_FFFF_FFFE;
    m_cnt = 64'h0000_0001_FFFF_FFFE;
    drive(6, 1'b1, 1'b0, 32'h0, 8'h0);
    tick();
    release dut_l1.cnt_r;
    release dut_l2.cnt_r;
    release dut_l3.cnt_r;
    idle();
    checks++;
    if (rdv[0] !== 1'b1 || rdd[0] !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL cnt_lo: got v=%b d=%h want v=1 d=fffffffe", rdv[0], rdd[0]);
    end
    for (int c = 0; c < 4; c++) tick();
    drive(7, 1'b1, 1'b0, 32'h0, 8'h0);
    tick();
    idle();
    checks++;
    if (rdv[0] !== 1'b1 || rdd[0] !== 32'h0000_0001) begin
      failures++;
      $display("FAIL cnt_hi_snapshot: got v=%b d=%h want v=1 d=00000001", rdv[0], rdd[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    drive(0, 1'b1, 1'b0, 32'h0, 8'hFF);
    tick();
    idle();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdv[i] !== 1'b0 || sts[i] !== 8'h0) begin
        failures++;
        $display("FAIL async_reset_now inst%0d: got v=%b st=%h want 0/00", i, rdv[i], sts[i]);
      end
    end
    tick();
    reset_n = 1'b1;
    exp_d.delete();
    for (int c = 0; c < 4; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rdv[i] !== 1'b0) begin
          failures++;
          $display("FAIL stale_valid_after_reset L%0d c%0d: got %b want 0", i+1, c, rdv[i]);
        end
      end
    end
    checks++;
    if (sts[1] !== 8'h0 || ctrl_o[1] !== 64'h0) begin
      failures++;
      $display("FAIL regs_after_reset: got st=%h ctrl=%h want 00/0", sts[1], ctrl_o[1]);
    end
    drive(6, 1'b1, 1'b0, 32'h0, 8'h0);   // four edges since reset release
    tick();
    idle();
    checks++;
    if (rdv[0] !== 1'b1 || rdd[0] !== 32'd4) begin
      failures++;
      $display("FAIL cnt_after_reset: got v=%b d=%h want v=1 d=00000004", rdv[0], rdd[0]);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    model_reset();
    for (int c = 0; c < 3; c++) tick();
    reset_n = 1'b1;
    #1;
    test_reset();
    test_id_back_to_back();
    test_latency3_single();
    test_unmapped_and_ignored_write();
    test_ctrl_write();
    test_rd_wr_same_index();
    test_status();
    test_random();
    test_counter_snapshot();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
